// File: rtl/mac_pkg.sv
// Shared encodings for the mac_array job sequencer: per-MAC valid_ctrl codes and FSM states.
package mac_pkg;

  localparam logic [2:0] VC_IDLE = 3'b000;
  localparam logic [2:0] VC_FEED = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_W,
    STREAM,
    DRAIN,
    OUTPUT
  } state_e;

endpackage

// File: rtl/mac_array_seq.sv
// Job sequencer for the 2x2 mac_array: clear, load weights, stream activations,
// drain the array pipeline and hand the four accumulators to the result consumer.
module mac_array_seq
  import mac_pkg::*;
#(
  parameter int W         = 8,
  parameter int ACC_W     = 16,
  parameter int N_MACS    = 4,
  parameter int K_W       = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [K_W-1:0]        start_len,
  input  logic [2:0]            start_acc_sel,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [4*ACC_W-1:0]    w_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ACC_W-1:0]      a_data,
  output logic [3*N_MACS-1:0]   arr_valid_ctrl,
  output logic [N_MACS-1:0]     arr_clear,
  output logic [N_MACS-1:0]     arr_valid_w,
  output logic [ACC_W-1:0]      arr_a_in,
  output logic [4*ACC_W-1:0]    arr_w,
  output logic [2:0]            arr_acc_sel,
  input  logic [4*ACC_W-1:0]    arr_acc,
  input  logic [N_MACS-1:0]     arr_valid_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4*ACC_W-1:0]    res_data,
  output logic                  res_err,
  output logic                  busy,
  output logic                  done
);

  if (N_MACS != 4 || W > ACC_W) begin : g_cfg_check
    $error("mac_array_seq: only N_MACS=4 with W<=ACC_W is supported");
  end

  state_e               state_q, state_d;
  logic [K_W-1:0]       cnt_q, cnt_d;
  logic [K_W-1:0]       len_q, len_d;
  logic [2:0]           acc_sel_q, acc_sel_d;
  logic [3*N_MACS-1:0]  arr_valid_ctrl_q, arr_valid_ctrl_d;
  logic [N_MACS-1:0]    arr_clear_q, arr_clear_d;
  logic [N_MACS-1:0]    arr_valid_w_q, arr_valid_w_d;
  logic [ACC_W-1:0]     arr_a_in_q, arr_a_in_d;
  logic [4*ACC_W-1:0]   arr_w_q, arr_w_d;
  logic [4*ACC_W-1:0]   res_data_q, res_data_d;
  logic                 res_err_q, res_err_d;

  // One counter serves both phases: handshakes seen in STREAM, elapsed cycles in DRAIN.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    len_d            = len_q;
    acc_sel_d        = acc_sel_q;
    arr_valid_ctrl_d = {N_MACS{VC_IDLE}};
    arr_clear_d      = '0;
    arr_valid_w_d    = '0;
    arr_a_in_d       = arr_a_in_q;
    arr_w_d          = arr_w_q;
    res_data_d       = res_data_q;
    res_err_d        = res_err_q;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          len_d       = start_len;
          acc_sel_d   = start_acc_sel;
          arr_clear_d = {N_MACS{1'b1}};
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        state_d = LOAD_W;
      end
      LOAD_W: begin
        if (w_valid) begin
          arr_w_d       = w_data;
          arr_valid_w_d = {N_MACS{1'b1}};
          cnt_d         = '0;
          state_d       = (len_q == '0) ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (a_valid) begin
          arr_a_in_d       = a_data;
          arr_valid_ctrl_d = {N_MACS{VC_FEED}};
          // Compare against len-1 so len=2^K_W-1 never needs the counter to wrap.
          if (cnt_q == len_q - K_W'(1)) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + K_W'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == K_W'(DRAIN_CYC - 1)) begin
          res_data_d = arr_acc;
          res_err_d  = (arr_valid_out != {N_MACS{1'b1}}) && (len_q != '0);
          cnt_d      = '0;
          state_d    = OUTPUT;
        end else begin
          cnt_d = cnt_q + K_W'(1);
        end
      end
      OUTPUT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      len_q            <= '0;
      acc_sel_q        <= '0;
      arr_valid_ctrl_q <= '0;
      arr_clear_q      <= '0;
      arr_valid_w_q    <= '0;
      arr_a_in_q       <= '0;
      arr_w_q          <= '0;
      res_data_q       <= '0;
      res_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      len_q            <= len_d;
      acc_sel_q        <= acc_sel_d;
      arr_valid_ctrl_q <= arr_valid_ctrl_d;
      arr_clear_q      <= arr_clear_d;
      arr_valid_w_q    <= arr_valid_w_d;
      arr_a_in_q       <= arr_a_in_d;
      arr_w_q          <= arr_w_d;
      res_data_q       <= res_data_d;
      res_err_q        <= res_err_d;
    end
  end

  // start_ready stays low while reset is asserted even though the state is already IDLE.
  assign start_ready    = rst && (state_q == IDLE);
  assign w_ready        = (state_q == LOAD_W);
  assign a_ready        = (state_q == STREAM);
  assign busy           = (state_q != IDLE);
  assign res_valid      = (state_q == OUTPUT);
  assign done           = res_valid && res_ready;

  assign arr_valid_ctrl = arr_valid_ctrl_q;
  assign arr_clear      = arr_clear_q;
  assign arr_valid_w    = arr_valid_w_q;
  assign arr_a_in       = arr_a_in_q;
  assign arr_w          = arr_w_q;
  assign arr_acc_sel    = acc_sel_q;
  assign res_data       = res_data_q;
  assign res_err        = res_err_q;

endmodule

// File: tb/tb_mac_array_seq.sv
// Self-checking bench for mac_array_seq with a behavioural 2x2 mac_array attached to the arr_* pins.
module tb_mac_array_seq;

  localparam int W         = 8;
  localparam int ACC_W     = 16;
  localparam int N_MACS    = 4;
  localparam int K_W       = 8;
  localparam int DRAIN_CYC = 3;

  logic                clk;
  logic                rst;
  logic                start_valid;
  logic                start_ready;
  logic [K_W-1:0]      start_len;
  logic [2:0]          start_acc_sel;
  logic                w_valid;
  logic                w_ready;
  logic [4*ACC_W-1:0]  w_data;
  logic                a_valid;
  logic                a_ready;
  logic [ACC_W-1:0]    a_data;
  logic [3*N_MACS-1:0] arr_valid_ctrl;
  logic [N_MACS-1:0]   arr_clear;
  logic [N_MACS-1:0]   arr_valid_w;
  logic [ACC_W-1:0]    arr_a_in;
  logic [4*ACC_W-1:0]  arr_w;
  logic [2:0]          arr_acc_sel;
  logic [4*ACC_W-1:0]  arr_acc;
  logic [N_MACS-1:0]   arr_valid_out;
  logic                res_valid;
  logic                res_ready;
  logic [4*ACC_W-1:0]  res_data;
  logic                res_err;
  logic                busy;
  logic                done;

  int checks   = 0;
  int failures = 0;
  int feed_cnt = 0;
  int ardy_cnt = 0;
  bit force_err = 0;
  logic [15:0] act_q[$];
  logic [6:0]  pat = 7'b1011001;

  mac_array_seq #(
    .W(W), .ACC_W(ACC_W), .N_MACS(N_MACS), .K_W(K_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_len(start_len), .start_acc_sel(start_acc_sel),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .arr_valid_ctrl(arr_valid_ctrl), .arr_clear(arr_clear), .arr_valid_w(arr_valid_w),
    .arr_a_in(arr_a_in), .arr_w(arr_w), .arr_acc_sel(arr_acc_sel),
    .arr_acc(arr_acc), .arr_valid_out(arr_valid_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Behavioural mac_array: clear zeroes, weight strobe loads, FEED code accumulates a*w.
  logic [ACC_W-1:0] m_acc[4] = '{default: '0};
  logic [W-1:0]     m_w[4]   = '{default: '0};
  logic [3:0]       m_vo     = '0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (arr_clear[i]) begin
        m_acc[i] <= '0;
        m_vo[i]  <= 1'b0;
      end else if (arr_valid_ctrl[3*i +: 3] == 3'b001) begin
        m_acc[i] <= m_acc[i] + ACC_W'(arr_a_in[W-1:0] * m_w[i]);
        m_vo[i]  <= 1'b1;
      end
      if (arr_valid_w[i]) m_w[i] <= arr_w[i*ACC_W +: W];
    end
  end

  assign arr_acc       = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
  assign arr_valid_out = force_err ? 4'b0111 : m_vo;

  always @(posedge clk) begin
    if (arr_valid_ctrl == 12'h249) feed_cnt++;
    if (a_ready) ardy_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rand(input int len);
    act_q.delete();
    for (int j = 0; j < len; j++) act_q.push_back(16'($urandom));
  endtask

  // Drives one whole job using act_q as the activation list; mode 0 dense, 1 random bubbles, 2 pattern.
  task automatic run_job(input int len, input logic [2:0] sel, input logic [63:0] wd,
                         input int mode, input int stall, input bit ferr);
    int idx, cyc, fb, ab;
    int unsigned s;
    logic [63:0] exp_d;
    logic [15:0] last_a;
    bit v, exp_e;
    exp_d = '0;
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int j = 0; j < len; j++) s += act_q[j][7:0] * wd[i*16 +: 8];
      exp_d[i*16 +: 16] = s[15:0];
    end
    exp_e = ferr && (len != 0);

    cyc = 0;
    while (!start_ready && cyc < 50) begin step(); cyc++; end
    chk("start_ready_idle", start_ready, 1);
    fb = feed_cnt;
    ab = ardy_cnt;
    start_valid = 1; start_len = K_W'(len); start_acc_sel = sel;
    step();
    start_valid = 0;
    w_valid = 1; w_data = wd;
    chk("clear_pulse", arr_clear, 4'hF);
    chk("acc_sel", arr_acc_sel, sel);
    chk("busy", busy, 1);
    step();
    chk("clear_once", arr_clear, 0);
    chk("w_ignored_in_clear", arr_valid_w, 0);
    chk("w_ready", w_ready, 1);
    step();
    w_valid = 0;
    chk("valid_w", arr_valid_w, 4'hF);
    chk("arr_w", arr_w, wd);

    idx = 0; cyc = 0;
    while (idx < len && cyc < 4*len + 20) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 2) != 0) : pat[cyc % 7];
      a_valid = v;
      a_data  = v ? act_q[idx] : 16'($urandom);
      step();
      cyc++;
      if (v) begin
        idx++;
        chk("feed_vc", arr_valid_ctrl, 12'h249);
        chk("a_in", arr_a_in, act_q[idx-1]);
      end else begin
        chk("bubble_vc", arr_valid_ctrl, 0);
      end
    end
    chk("len_consumed", idx, len);

    last_a = arr_a_in;
    a_valid = 1; a_data = ~last_a; w_valid = 1; w_data = ~wd; start_valid = 1;
    force_err = ferr;
    for (int k = 0; k < DRAIN_CYC - 1; k++) begin
      step();
      chk("drain_wait", res_valid, 0);
    end
    step();
    force_err = 0;
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, exp_d);
    chk("res_err", res_err, exp_e);
    chk("stray_vc", arr_valid_ctrl, 0);
    chk("stray_vw", arr_valid_w, 0);
    chk("stray_a_hold", arr_a_in, last_a);
    chk("stray_w_hold", arr_w, wd);
    chk("no_accept_out", start_ready, 0);
    chk("feed_count", feed_cnt - fb, len);
    if (len == 0) chk("no_a_ready", ardy_cnt - ab, 0);

    for (int k = 0; k < stall; k++) begin
      step();
      chk("stall_valid", res_valid, 1);
      chk("stall_data", res_data, exp_d);
      chk("stall_no_start", start_ready, 0);
    end
    a_valid = 0; w_valid = 0; start_valid = 0;
    res_ready = 1;
    #1;
    chk("done", done, 1);
    step();
    res_ready = 0;
    #1;
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);
    chk("ready_again", start_ready, 1);
  endtask

  initial begin
    rst = 0; start_valid = 0; start_len = '0; start_acc_sel = '0;
    w_valid = 0; w_data = '0; a_valid = 0; a_data = '0; res_ready = 0;
    step(); step(); step();
    chk("rst_start_ready", start_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_vc", arr_valid_ctrl, 0);
    chk("rst_res_data", res_data, 0);
    rst = 1;
    #1;
    chk("rst_release_ready", start_ready, 1);
    step();

    // Directed: w=(1,2,3,4), a=5,6,7
    act_q = '{16'd5, 16'd6, 16'd7};
    run_job(3, 3'd5, {16'd4, 16'd3, 16'd2, 16'd1}, 0, 0, 0);
    chk("t1_golden", res_data, 64'h0048_0036_0024_0012);

    // Empty job
    act_q.delete();
    run_job(0, 3'd2, 64'h1234_5678_9abc_def0, 0, 0, 0);
    chk("t2_zero", res_data, 0);

    // Bubble pattern 1,0,0,1,1,0,1
    fill_rand(4);
    run_job(4, 3'd1, {16'd9, 16'd7, 16'd5, 16'd3}, 2, 0, 0);

    // Result consumer stalls 20 cycles
    fill_rand(3);
    run_job(3, 3'd6, {4{16'($urandom)}}, 1, 20, 0);

    // Reset in the middle of streaming
    fill_rand(5);
    start_valid = 1; start_len = 8'd5; start_acc_sel = 3'd7;
    step();
    start_valid = 0; w_valid = 1; w_data = 64'hffff_eeee_dddd_cccc;
    step(); step();
    w_valid = 0;
    a_valid = 1; a_data = act_q[0]; step();
    a_data = act_q[1]; step();
    a_data = act_q[2]; rst = 0;
    step();
    chk("mid_rst_start_ready", start_ready, 0);
    chk("mid_rst_w_ready", w_ready, 0);
    chk("mid_rst_a_ready", a_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_vc", arr_valid_ctrl, 0);
    chk("mid_rst_clear", arr_clear, 0);
    chk("mid_rst_vw", arr_valid_w, 0);
    chk("mid_rst_a_in", arr_a_in, 0);
    chk("mid_rst_w", arr_w, 0);
    chk("mid_rst_sel", arr_acc_sel, 0);
    chk("mid_rst_res", res_data, 0);
    chk("mid_rst_err", res_err, 0);
    a_valid = 0; rst = 1;
    step();
    fill_rand(1);
    run_job(1, 3'd3, {4{16'($urandom)}}, 0, 0, 0);

    // Incomplete valid_out at capture
    fill_rand(2);
    run_job(2, 3'd4, {4{16'($urandom)}}, 0, 0, 1);

    // Randomized jobs
    for (int n = 0; n < 6; n++) begin
      int len;
      len = $urandom_range(0, 12);
      fill_rand(len);
      run_job(len, 3'($urandom), {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)},
              1, $urandom_range(0, 3), 0);
    end

    // Maximum length
    fill_rand(255);
    run_job(255, 3'd0, {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)}, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
